// File: rtl/line_sync_scheduler.sv
// line_sync_scheduler
// Sequences reads from the network-receive pixel FIFO (first-word-fall-through)
// so that each displayed line only receives pixels tagged for that line.
// Before every active line it discards stale words, aligns on the matching
// y_count tag, then streams one pixel per display request. Underruns and
// missing lines are rendered black.
//
// FIFO word layout: [28:27] x_count, [26:16] y_count tag, [15:0] pixel.
//
// Ports:
//   i_clk_74M       pixel clock
//   i_rst           asynchronous active-high reset
//   i_vcnt/i_hcnt   timing generator counters
//   i_disp_req      display active window; one pixel consumed per high cycle
//   i_fifo_data     FIFO head word
//   i_fifo_empty    FIFO empty
//   o_fifo_rd       pop head word (combinational, never while empty)
//   o_data          delivered word, registered, zero when not a real pixel
//   o_valid         o_data holds a real FIFO pixel
//   o_locked        previous active line was delivered complete
//   o_drop_cnt      stale words discarded (saturating)
//   o_underrun_cnt  black pixels inserted while streaming (saturating)
module line_sync_scheduler #(
   parameter int VSTART = 24,
   parameter int VFIN   = 745,
   parameter int SEEK_H = 1300,
   parameter int LINE_W = 1200,
   parameter int TAG_W  = 11
) (
   input  logic        i_clk_74M,
   input  logic        i_rst,
   input  logic [11:0] i_vcnt,
   input  logic [11:0] i_hcnt,
   input  logic        i_disp_req,
   input  logic [28:0] i_fifo_data,
   input  logic        i_fifo_empty,
   output logic        o_fifo_rd,
   output logic [28:0] o_data,
   output logic        o_valid,
   output logic        o_locked,
   output logic [15:0] o_drop_cnt,
   output logic [15:0] o_underrun_cnt
);

   localparam int CW = $clog2(LINE_W + 1);

   typedef enum logic [2:0] {IDLE, SEEK, READY, SKIP, STREAM, BLANK} state_t;

   state_t           state;
   logic [TAG_W-1:0] expected;
   logic [TAG_W-1:0] tag;
   logic [TAG_W-1:0] diff;
   logic [CW-1:0]    pix_cnt;
   logic [CW-1:0]    good_cnt;
   logic [CW-1:0]    good_next;
   logic [11:0]      vnext;
   logic             req_d;
   logic             rise;
   logic             is_match;
   logic             is_stale;
   logic             head_ok;
   logic             stream_cyc;
   logic             blank_cyc;
   logic             seek_cyc;
   logic             last_pix;
   logic             seek_start;
   logic             drop_inc;
   logic             under_inc;

   // Modulo tag compare: a difference in the upper half of the tag space
   // means the head word belongs to a line that has already gone by.
   assign tag      = i_fifo_data[16 +: TAG_W];
   assign diff     = tag - expected;
   assign is_match = (diff == '0);
   assign is_stale = diff[TAG_W-1];
   assign head_ok  = ~i_fifo_empty & is_match;

   assign rise = i_disp_req & ~req_d;

   // The rising request cycle already consumes the first pixel, so a line
   // is counted from the cycle the state machine leaves SEEK/READY/SKIP/IDLE.
   assign stream_cyc = i_disp_req & ((state == STREAM) |
                                     (rise & ((state == SEEK) | (state == READY))));
   assign blank_cyc  = i_disp_req & ((state == BLANK) |
                                     (rise & ((state == SKIP) | (state == IDLE))));
   assign seek_cyc   = (state == SEEK) & ~stream_cyc;

   assign o_fifo_rd = ~i_fifo_empty & ((is_stale & (seek_cyc | stream_cyc)) |
                                       (is_match & stream_cyc));

   assign drop_inc  = o_fifo_rd & is_stale;
   assign under_inc = stream_cyc & (i_fifo_empty | (~is_match & ~is_stale));

   assign last_pix   = (pix_cnt == CW'(LINE_W - 1));
   assign good_next  = good_cnt + CW'(head_ok);
   assign vnext      = i_vcnt + 12'd1 - 12'(VSTART);
   assign seek_start = (i_hcnt == 12'(SEEK_H)) &&
                       (i_vcnt >= 12'(VSTART - 1)) && (i_vcnt <= 12'(VFIN - 2));

   always_ff @(posedge i_clk_74M or posedge i_rst) begin
      if (i_rst) begin
         state          <= IDLE;
         req_d          <= 1'b0;
         expected       <= '0;
         pix_cnt        <= '0;
         good_cnt       <= '0;
         o_data         <= '0;
         o_valid        <= 1'b0;
         o_locked       <= 1'b0;
         o_drop_cnt     <= '0;
         o_underrun_cnt <= '0;
      end else begin
         req_d   <= i_disp_req;
         o_data  <= '0;
         o_valid <= 1'b0;

         if (drop_inc && (o_drop_cnt != 16'hFFFF))
            o_drop_cnt <= o_drop_cnt + 16'd1;
         if (under_inc && (o_underrun_cnt != 16'hFFFF))
            o_underrun_cnt <= o_underrun_cnt + 16'd1;

         if (stream_cyc) begin
            if (head_ok) begin
               o_data   <= i_fifo_data;
               o_valid  <= 1'b1;
               good_cnt <= good_next;
            end
            if (last_pix) begin
               state    <= IDLE;
               pix_cnt  <= '0;
               o_locked <= (good_next == CW'(LINE_W));
            end else begin
               state   <= STREAM;
               pix_cnt <= pix_cnt + CW'(1);
            end
         end else if (blank_cyc) begin
            if (last_pix) begin
               state    <= IDLE;
               pix_cnt  <= '0;
               o_locked <= 1'b0;
            end else begin
               state   <= BLANK;
               pix_cnt <= pix_cnt + CW'(1);
            end
         end else begin
            case (state)
               IDLE: begin
                  if (seek_start) begin
                     state    <= SEEK;
                     expected <= vnext[TAG_W-1:0];
                     pix_cnt  <= '0;
                     good_cnt <= '0;
                  end
               end
               SEEK: begin
                  // Stale heads are popped by o_fifo_rd; stop on the first
                  // head that is current or from a future line.
                  if (!i_fifo_empty && !is_stale)
                     state <= is_match ? READY : SKIP;
               end
               // Request fell before LINE_W pixels: the line is incomplete.
               STREAM, BLANK: begin
                  state    <= IDLE;
                  pix_cnt  <= '0;
                  o_locked <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
